alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
Parameters:
REQ-001 DEPTH, 4, request FIFO entries (power of two, >=2).
REQ-002 ALU_LAT, 2, rising edges from ALU input sampling to stable ALU out/carry.
Ports:
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  upstream op request present.
REQ-006 req_ready  output  1  FIFO can accept; asserted when FIFO not full.
REQ-007 req_in1, req_in2  input  4 each  operands.
REQ-008 req_sel  input  2  opcode: 00 add, 01 sub, 10 mul, 11 illegal.
REQ-009 alu_in1, alu_in2  output  4 each  registered operands driven to the ALU.
REQ-010 alu_sel  output  2  registered opcode driven to the ALU.
REQ-011 alu_out  input  4  ALU result low nibble.
REQ-012 alu_carry  input  1  ALU overflow flag (any of result bits 7:4 set).
REQ-013 res_valid  output  1  result register holds an unconsumed result.
REQ-014 res_ready  input  1  downstream accepts result.
REQ-015 res_data  output  4  captured result; res_carry output 1, captured carry.
REQ-016 err  output  1  one-cycle pulse: illegal opcode dropped.

Function
REQ-017 Request accepted on a rising edge when req_valid && req_ready; {in1,in2,sel} written to FIFO tail.
REQ-018 FIFO full (count==DEPTH): req_ready=0, no write; empty: no pop; simultaneous push and pop when full is not permitted (req_ready already 0); when empty, a pushed entry is poppable no earlier than the next edge.
REQ-019 Pointers wrap modulo DEPTH; count range 0..DEPTH, no entry lost or duplicated across wrap.
REQ-020 FSM states: IDLE, ISSUE, WAIT, HOLD; exactly one op in flight.
REQ-021 IDLE: if FIFO non-empty, pop head; if head sel==11, drop it, pulse err for one cycle, stay IDLE; else load alu_in1/alu_in2/alu_sel from head, go ISSUE.
REQ-022 ISSUE: one cycle with ALU inputs stable; load wait counter with ALU_LAT, go WAIT.
REQ-023 WAIT: decrement counter each edge; on the edge where counter==1, capture alu_out->res_data and alu_carry->res_carry, set res_valid=1, go HOLD.
REQ-024 Total: capture on the (ALU_LAT+1)th rising edge after the issue (IDLE->ISSUE) edge; alu_in*/alu_sel held unchanged from issue through capture.
REQ-025 HOLD: res_valid=1, res_data/res_carry stable; when res_ready=1 on an edge, clear res_valid and go IDLE; with FIFO non-empty next op issues on the following edge (minimum 1 idle cycle between ops).
REQ-026 res_ready while res_valid=0 has no effect.
REQ-027 FIFO accepts requests in every state, independent of FSM.
REQ-028 Arithmetic is performed only by the ALU; res_data/res_carry are copied verbatim, no re-widening or masking.

Reset
REQ-029 rst=1 asynchronously forces: FSM IDLE, FIFO empty (count 0, pointers 0), req_ready=0 while rst high then 1 on first edge after release, alu_in1=alu_in2=0, alu_sel=00, res_valid=0, res_data=0, res_carry=0, err=0, wait counter 0.
REQ-030 Reset mid-operation (any state) discards FIFO contents and any in-flight op; no result or err is produced for them after release.

Verification
REQ-031 Single add: push (3,4,00), res_ready=1 -> res_valid rises 4th edge after push (pop edge + ALU_LAT+1), res_data=7, res_carry=0.
REQ-032 Mul overflow: push (6,A,10) -> res_data=C, res_carry=1; sub underflow (2,3,01) -> res_data=F, res_carry=1.
REQ-033 Back-pressure: hold res_ready=0, push 5 ops -> first result held stable, req_ready=0 after FIFO holds DEPTH entries; release res_ready -> all 5 results emerge in push order.
REQ-034 Illegal op: push (1,1,11) then (2,2,00) -> single err pulse, no res_valid for first, next res_data=4, res_carry=0.
REQ-035 Reset mid-WAIT with 2 queued ops: assert rst -> all outputs at reset values immediately; after release no res_valid until new push.
REQ-036 Wrap: push/consume 3*DEPTH+1 ops with random gaps -> scoreboard matches every result in order.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Queues ALU operation requests in a small FIFO and issues them one at a time
// to an external fixed-latency ALU, holding each result until downstream takes it.
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_in1,
    input  logic [3:0] req_in2,
    input  logic [1:0] req_sel,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_carry,
    output logic       err
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int WAIT_W  = $clog2(ALU_LAT + 1);
    localparam int ENTRY_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t              state_q, state_d;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [ENTRY_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, ready_d;

    logic [3:0]          alu_in1_q, alu_in1_d;
    logic [3:0]          alu_in2_q, alu_in2_d;
    logic [1:0]          alu_sel_q, alu_sel_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                res_valid_q, res_valid_d;
    logic [3:0]          res_data_q, res_data_d;
    logic                res_carry_q, res_carry_d;
    logic                err_q, err_d;

    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  entry_in;
    logic [ENTRY_W-1:0]  head;
    logic [3:0]          head_in1;
    logic [3:0]          head_in2;
    logic [1:0]          head_sel;

    // ready_q keeps req_ready low during reset and for the cycle it is released
    assign req_ready  = ready_q && (count_q != CNT_W'(DEPTH));
    assign push       = req_valid && req_ready;
    assign fifo_empty = (count_q == '0);
    assign entry_in   = {req_in1, req_in2, req_sel};

    assign head       = mem_q[rd_ptr_q];
    assign head_in1   = head[9:6];
    assign head_in2   = head[5:2];
    assign head_sel   = head[1:0];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ready_d  = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = entry_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        err_d       = 1'b0;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_sel_d   = alu_sel_q;
        wait_cnt_d  = wait_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // Illegal opcodes never reach the ALU; they are only flagged
                    if (head_sel == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        alu_in1_d = head_in1;
                        alu_in2_d = head_in2;
                        alu_sel_d = head_sel;
                        state_d   = ISSUE;
                    end
                end
            end

            ISSUE: begin
                wait_cnt_d = WAIT_W'(ALU_LAT);
                state_d    = WAIT;
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    wait_cnt_d  = '0;
                    res_data_d  = alu_out;
                    res_carry_d = alu_carry;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_sel_q   <= '0;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_sel_q   <= alu_sel_d;
            wait_cnt_q  <= wait_cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            err_q       <= err_d;
        end
    end

    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a pipelined ALU stand-in feeds the DUT,
// and each task drives one scenario and checks its own expected values.
module tb_alu_op_sequencer;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_in1 = '0;
    logic [3:0] req_in2 = '0;
    logic [1:0] req_sel = '0;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [1:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_carry;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q [$];

    alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_sel   (req_sel),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Returns {carry, low nibble} of the 8-bit ALU result
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        logic [7:0] r;
        case (s)
            2'b00:   r = {4'h0, a} + {4'h0, b};
            2'b01:   r = {4'h0, a} - {4'h0, b};
            default: r = {4'h0, a} * {4'h0, b};
        endcase
        return {|r[7:4], r[3:0]};
    endfunction

    // External ALU with ALU_LAT register stages
    logic [4:0] alu_pipe [ALU_LAT] = '{default: 5'h00};
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_in1, alu_in2, alu_sel);
        for (int i = 1; i < ALU_LAT; i++) begin
            alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign alu_out   = alu_pipe[ALU_LAT-1][3:0];
    assign alu_carry = alu_pipe[ALU_LAT-1][4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        int w = 0;
        req_in1   = a;
        req_in2   = b;
        req_sel   = s;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL push_ready_timeout: req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        int w = 0;
        while (res_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        total++;
        ok = (res_valid === 1'b1);
        if (!ok) begin
            bad++;
            $display("[TB] FAIL result_timeout: res_valid=%b expected 1", res_valid);
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        total += 8;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_ready: got %b expected 0", req_ready); end
        if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_res_valid: got %b expected 0", res_valid); end
        if (res_data !== 4'h0)  begin bad++; $display("[TB] FAIL rst_res_data: got %h expected 0", res_data); end
        if (res_carry !== 1'b0) begin bad++; $display("[TB] FAIL rst_res_carry: got %b expected 0", res_carry); end
        if (err !== 1'b0)       begin bad++; $display("[TB] FAIL rst_err: got %b expected 0", err); end
        if (alu_in1 !== 4'h0)   begin bad++; $display("[TB] FAIL rst_alu_in1: got %h expected 0", alu_in1); end
        if (alu_in2 !== 4'h0)   begin bad++; $display("[TB] FAIL rst_alu_in2: got %h expected 0", alu_in2); end
        if (alu_sel !== 2'b00)  begin bad++; $display("[TB] FAIL rst_alu_sel: got %b expected 00", alu_sel); end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rel_ready_early: got %b expected 0", req_ready); end
        tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_ready: got %b expected 1", req_ready); end
    endtask

    // 3+4 with res_ready already high: result visible after the 4th edge from the push
    task automatic test_single_add();
        res_ready = 1'b1;
        req_in1   = 4'h3;
        req_in2   = 4'h4;
        req_sel   = 2'b00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (k < 4) begin
                if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_early_valid: edge %0d res_valid=%b expected 0", k, res_valid); end
            end else begin
                if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: res_valid=%b expected 1", res_valid); end
            end
        end
        total += 4;
        if (res_data !== 4'h7)  begin bad++; $display("[TB] FAIL add_data: got %h expected 7", res_data); end
        if (res_carry !== 1'b0) begin bad++; $display("[TB] FAIL add_carry: got %b expected 0", res_carry); end
        if (alu_in1 !== 4'h3)   begin bad++; $display("[TB] FAIL add_alu_in1: got %h expected 3", alu_in1); end
        if (alu_in2 !== 4'h4)   begin bad++; $display("[TB] FAIL add_alu_in2: got %h expected 4", alu_in2); end
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_consumed: res_valid=%b expected 0", res_valid); end
    endtask

    task automatic test_mul_sub();
        bit ok;
        res_ready = 1'b0;
        push_one(4'h6, 4'hA, 2'b10);
        wait_result(ok);
        if (ok) begin
            total += 2;
            if (res_data !== 4'hC)  begin bad++; $display("[TB] FAIL mul_data: got %h expected c", res_data); end
            if (res_carry !== 1'b1) begin bad++; $display("[TB] FAIL mul_carry: got %b expected 1", res_carry); end
        end
        consume();
        push_one(4'h2, 4'h3, 2'b01);
        wait_result(ok);
        if (ok) begin
            total += 2;
            if (res_data !== 4'hF)  begin bad++; $display("[TB] FAIL sub_data: got %h expected f", res_data); end
            if (res_carry !== 1'b1) begin bad++; $display("[TB] FAIL sub_carry: got %b expected 1", res_carry); end
        end
        consume();
    endtask

    // Expected: 1+2=3/0, 9+9=0x12 -> 2/1, 7-2=5/0, 3*5=0x0F -> F/0, 4*4=0x10 -> 0/1
    task automatic test_back_pressure();
        logic [3:0] a_v [5] = '{4'h1, 4'h9, 4'h7, 4'h3, 4'h4};
        logic [3:0] b_v [5] = '{4'h2, 4'h9, 4'h2, 4'h5, 4'h4};
        logic [1:0] s_v [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
        logic [3:0] d_v [5] = '{4'h3, 4'h2, 4'h5, 4'hF, 4'h0};
        logic       c_v [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit ok;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(a_v[i], b_v[i], s_v[i]);
        end
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready: got %b expected 0", req_ready); end
        wait_result(ok);
        for (int k = 0; k < 3; k++) begin
            tick();
            total += 2;
            if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid: got %b expected 1", res_valid); end
            if (res_data !== d_v[0]) begin bad++; $display("[TB] FAIL bp_hold_data: got %h expected %h", res_data, d_v[0]); end
        end
        for (int i = 0; i < 5; i++) begin
            wait_result(ok);
            if (!ok) break;
            total += 2;
            if (res_data !== d_v[i])  begin bad++; $display("[TB] FAIL bp_data_%0d: got %h expected %h", i, res_data, d_v[i]); end
            if (res_carry !== c_v[i]) begin bad++; $display("[TB] FAIL bp_carry_%0d: got %b expected %b", i, res_carry, c_v[i]); end
            consume();
        end
    endtask

    task automatic test_illegal();
        int  errs = 0;
        int  w    = 0;
        bit  seen = 1'b0;
        res_ready = 1'b0;
        req_in1   = 4'h1;
        req_in2   = 4'h1;
        req_sel   = 2'b11;
        req_valid = 1'b1;
        tick();
        if (err === 1'b1) errs++;
        req_in1 = 4'h2;
        req_in2 = 4'h2;
        req_sel = 2'b00;
        tick();
        if (err === 1'b1) errs++;
        req_valid = 1'b0;
        while (res_valid !== 1'b1 && w < 30) begin
            tick();
            if (err === 1'b1) errs++;
            w++;
        end
        total += 4;
        if (errs != 1)          begin bad++; $display("[TB] FAIL ill_err_pulses: got %0d expected 1", errs); end
        if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL ill_valid: got %b expected 1", res_valid); end
        if (res_data !== 4'h4)  begin bad++; $display("[TB] FAIL ill_data: got %h expected 4", res_data); end
        if (res_carry !== 1'b0) begin bad++; $display("[TB] FAIL ill_carry: got %b expected 0", res_carry); end
        consume();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (res_valid === 1'b1 || err === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("[TB] FAIL ill_extra_output: got activity expected none"); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit seen = 1'b0;
        res_ready = 1'b0;
        req_valid = 1'b1;
        req_in1 = 4'h5; req_in2 = 4'h3; req_sel = 2'b10;
        tick();
        req_in1 = 4'h1; req_in2 = 4'h1; req_sel = 2'b00;
        tick();
        req_in1 = 4'h2; req_in2 = 4'h2; req_sel = 2'b00;
        tick();
        req_valid = 1'b0;
        total += 2;
        if (alu_in1 !== 4'h5)  begin bad++; $display("[TB] FAIL mw_alu_in1: got %h expected 5", alu_in1); end
        if (alu_sel !== 2'b10) begin bad++; $display("[TB] FAIL mw_alu_sel: got %b expected 10", alu_sel); end
        rst = 1'b1;
        #1;
        total += 8;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL mw_req_ready: got %b expected 0", req_ready); end
        if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL mw_res_valid: got %b expected 0", res_valid); end
        if (res_data !== 4'h0)  begin bad++; $display("[TB] FAIL mw_res_data: got %h expected 0", res_data); end
        if (res_carry !== 1'b0) begin bad++; $display("[TB] FAIL mw_res_carry: got %b expected 0", res_carry); end
        if (err !== 1'b0)       begin bad++; $display("[TB] FAIL mw_err: got %b expected 0", err); end
        if (alu_in1 !== 4'h0)   begin bad++; $display("[TB] FAIL mw_rst_alu_in1: got %h expected 0", alu_in1); end
        if (alu_in2 !== 4'h0)   begin bad++; $display("[TB] FAIL mw_rst_alu_in2: got %h expected 0", alu_in2); end
        if (alu_sel !== 2'b00)  begin bad++; $display("[TB] FAIL mw_rst_alu_sel: got %b expected 00", alu_sel); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (res_valid === 1'b1 || err === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("[TB] FAIL mw_stale_output: got activity expected none"); end
        push_one(4'h8, 4'h1, 2'b01);
        wait_result(ok);
        if (ok) begin
            total += 2;
            if (res_data !== 4'h7)  begin bad++; $display("[TB] FAIL mw_new_data: got %h expected 7", res_data); end
            if (res_carry !== 1'b0) begin bad++; $display("[TB] FAIL mw_new_carry: got %b expected 0", res_carry); end
        end
        consume();
    endtask

    task automatic test_wrap();
        localparam int NOPS = 3 * DEPTH + 1;
        res_ready = 1'b0;
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < NOPS; i++) begin
                    logic [3:0] a;
                    logic [3:0] b;
                    logic [1:0] s;
                    a = 4'($urandom_range(0, 15));
                    b = 4'($urandom_range(0, 15));
                    s = 2'($urandom_range(0, 2));
                    repeat ($urandom_range(0, 3)) tick();
                    exp_q.push_back(alu_ref(a, b, s));
                    push_one(a, b, s);
                end
            end
            begin
                for (int n = 0; n < NOPS; n++) begin
                    bit ok;
                    logic [4:0] e;
                    wait_result(ok);
                    if (!ok) break;
                    repeat ($urandom_range(0, 3)) tick();
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL wrap_unexpected_%0d: got %h with no request pending", n, res_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({res_carry, res_data} !== e) begin
                            bad++;
                            $display("[TB] FAIL wrap_result_%0d: got carry=%b data=%h expected carry=%b data=%h",
                                     n, res_carry, res_data, e[4], e[3:0]);
                        end
                    end
                    consume();
                end
            end
        join
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_leftover: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_mul_sub();
        test_back_pressure();
        test_illegal();
        test_reset_mid_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
